// File: rtl/programmable_clock_divider.sv
// programmable_clock_divider: CHANNELS independent clockIn dividers with
// shadowed divisors and mode changes taking effect only at period boundaries.
module programmable_clock_divider #(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 24999,
   parameter int CH_BITS     = 2
) (
   input  logic                clockIn,
   input  logic                reset,
   input  logic                wrEn,
   input  logic [CH_BITS-1:0]  wrChannel,
   input  logic [WIDTH-1:0]    wrData,
   input  logic [CHANNELS-1:0] enable,
   input  logic [CHANNELS-1:0] pulseMode,
   output logic [CHANNELS-1:0] clockOut,
   output logic [CHANNELS-1:0] busy
);

   localparam logic [WIDTH-1:0] DefaultDiv = WIDTH'(DEFAULT_DIV);

   for (genvar g = 0; g < CHANNELS; g++) begin : gCh
      logic [WIDTH-1:0] counter;
      logic [WIDTH-1:0] activeDiv;
      logic [WIDTH-1:0] shadowDiv;
      logic             phase;
      logic             activeMode;
      logic             outReg;
      logic             pending;
      logic             tc;
      logic             wrHit;
      logic             nextPhase;
      logic             nextMode;

      // Out-of-range channel numbers match no generate index.
      assign wrHit     = wrEn && (32'(wrChannel) == g);
      assign tc        = enable[g] && (counter == activeDiv);
      assign nextPhase = phase ^ tc;
      // The output after TC already belongs to the new period's mode.
      assign nextMode  = tc ? pulseMode[g] : activeMode;

      always_ff @(posedge clockIn or posedge reset) begin
         if (reset) begin
            counter    <= '0;
            phase      <= 1'b0;
            activeMode <= 1'b0;
            outReg     <= 1'b0;
            pending    <= 1'b0;
            activeDiv  <= DefaultDiv;
            shadowDiv  <= DefaultDiv;
         end else if (!enable[g]) begin
            counter    <= '0;
            phase      <= 1'b0;
            outReg     <= 1'b0;
            activeMode <= pulseMode[g];
            pending    <= 1'b0;
            if (wrHit) begin
               shadowDiv <= wrData;
               activeDiv <= wrData;
            end else if (pending) begin
               activeDiv <= shadowDiv;
            end
         end else begin
            counter    <= tc ? '0 : counter + 1'b1;
            phase      <= nextPhase;
            activeMode <= nextMode;
            outReg     <= nextMode ? tc : nextPhase;
            if (tc && pending) begin
               activeDiv <= shadowDiv;
            end
            // A write on the TC edge stays pending for one more period.
            if (wrHit) begin
               shadowDiv <= wrData;
               pending   <= 1'b1;
            end else if (tc) begin
               pending   <= 1'b0;
            end
         end
      end

      assign clockOut[g] = outReg;
      assign busy[g]     = pending;
   end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// tb_programmable_clock_divider: directed vectors and corner sequences
// for the multi-channel programmable clock divider.
module tb_programmable_clock_divider;

   localparam int CH = 4;
   localparam int W  = 16;

   logic          clockIn = 1'b0;
   logic          reset = 1'b1;
   logic          wrEn = 1'b0;
   logic [1:0]    wrChannel = '0;
   logic [W-1:0]  wrData = '0;
   logic [CH-1:0] enable = '0;
   logic [CH-1:0] pulseMode = '0;
   logic [CH-1:0] clockOut;
   logic [CH-1:0] busy;
   logic [2:0]    clockOut3;
   logic [2:0]    busy3;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int   ch;
      int   div;
      logic mode;
      int   expRise;
      int   expHigh;
      int   expLow;
   } vec_t;

   vec_t vecs [5];

   programmable_clock_divider #(
      .CHANNELS(4), .WIDTH(W), .DEFAULT_DIV(24999), .CH_BITS(2)
   ) dut (
      .clockIn(clockIn), .reset(reset), .wrEn(wrEn),
      .wrChannel(wrChannel), .wrData(wrData),
      .enable(enable), .pulseMode(pulseMode),
      .clockOut(clockOut), .busy(busy)
   );

   programmable_clock_divider #(
      .CHANNELS(3), .WIDTH(W), .DEFAULT_DIV(24999), .CH_BITS(2)
   ) dut3 (
      .clockIn(clockIn), .reset(reset), .wrEn(wrEn),
      .wrChannel(wrChannel), .wrData(wrData),
      .enable(enable[2:0]), .pulseMode(pulseMode[2:0]),
      .clockOut(clockOut3), .busy(busy3)
   );

   always #10 clockIn = ~clockIn;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clockIn);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic waitLevel(input int ch, input logic lvl,
                            input int limit, output int n);
      n = 0;
      while (clockOut[ch] !== lvl) begin
         if (n >= limit) begin
            n = -1;
            return;
         end
         tick();
         n++;
      end
   endtask

   task automatic write(input logic [1:0] ch, input logic [W-1:0] d);
      wrEn = 1'b1;
      wrChannel = ch;
      wrData = d;
      tick();
      wrEn = 1'b0;
   endtask

   initial begin
      int n;
      vecs = '{
         '{1, 3, 1'b0, 4, 4, 4},
         '{0, 4, 1'b1, 5, 1, 4},
         '{2, 0, 1'b0, 1, 1, 1},
         '{3, 9, 1'b0, 10, 10, 10},
         '{2, 2, 1'b1, 3, 1, 2}
      };

      // Reset state and default 1 kHz square wave on every channel
      enable = 4'hF;
      pulseMode = 4'h0;
      tick(2);
      check("reset clockOut", 32'(clockOut), 0);
      check("reset busy", 32'(busy), 0);
      check("reset busy3", 32'(busy3), 0);
      reset = 1'b0;
      waitLevel(0, 1'b1, 30000, n);
      check("default rise", n, 25000);
      check("default all high", 32'(clockOut), 32'hF);
      waitLevel(0, 1'b0, 30000, n);
      check("default fall", n, 25000);
      check("default all low", 32'(clockOut), 0);
      check("default busy", 32'(busy), 0);

      // Disabled write, then enable: latency, high and low times
      for (int i = 0; i < 5; i++) begin
         enable = '0;
         pulseMode = '0;
         tick();
         pulseMode[vecs[i].ch] = vecs[i].mode;
         write(2'(vecs[i].ch), W'(vecs[i].div));
         check($sformatf("v%0d busy idle", i), 32'(busy[vecs[i].ch]), 0);
         enable[vecs[i].ch] = 1'b1;
         waitLevel(vecs[i].ch, 1'b1, 64, n);
         check($sformatf("v%0d rise", i), n, vecs[i].expRise);
         waitLevel(vecs[i].ch, 1'b0, 64, n);
         check($sformatf("v%0d high", i), n, vecs[i].expHigh);
         waitLevel(vecs[i].ch, 1'b1, 64, n);
         check($sformatf("v%0d low", i), n, vecs[i].expLow);
      end

      // Mid-period divisor change on ch2: 9 -> 1
      enable = '0;
      pulseMode = '0;
      tick();
      write(2'd2, 16'd9);
      enable = 4'b0100;
      waitLevel(2, 1'b1, 64, n);
      check("ch2 rise", n, 10);
      tick(3);
      write(2'd2, 16'd1);
      check("ch2 busy set", 32'(busy[2]), 1);
      tick(5);
      check("ch2 busy held", 32'(busy[2]), 1);
      check("ch2 still high", 32'(clockOut[2]), 1);
      waitLevel(2, 1'b0, 64, n);
      check("ch2 old period end", n, 1);
      check("ch2 busy clear", 32'(busy[2]), 0);
      waitLevel(2, 1'b1, 64, n);
      check("ch2 new low", n, 2);
      waitLevel(2, 1'b0, 64, n);
      check("ch2 new high", n, 2);

      // Pulse to square switch on ch0 waits for the next TC
      enable = '0;
      pulseMode = 4'b0001;
      tick();
      write(2'd0, 16'd4);
      enable = 4'b0001;
      waitLevel(0, 1'b1, 64, n);
      check("ch0 pulse rise", n, 5);
      tick();
      check("ch0 pulse width", 32'(clockOut[0]), 0);
      pulseMode = 4'b0000;
      waitLevel(0, 1'b1, 64, n);
      check("ch0 square rise", n, 9);
      waitLevel(0, 1'b0, 64, n);
      check("ch0 square high", n, 5);

      // Out-of-range write on the 3-channel instance
      enable = 4'hF;
      tick();
      write(2'd3, 16'd7);
      check("oor busy3", 32'(busy3), 0);
      check("ch3 busy 4ch", 32'(busy), 32'b1000);

      // Write on the same edge as TC on ch0
      enable = '0;
      pulseMode = '0;
      tick();
      write(2'd0, 16'd4);
      enable = 4'b0001;
      waitLevel(0, 1'b1, 64, n);
      check("tcw rise", n, 5);
      tick();
      write(2'd0, 16'd2);
      check("tcw busy first", 32'(busy[0]), 1);
      tick(2);
      check("tcw pre-TC high", 32'(clockOut[0]), 1);
      write(2'd0, 16'd1);
      check("tcw busy kept", 32'(busy[0]), 1);
      check("tcw fall", 32'(clockOut[0]), 0);
      waitLevel(0, 1'b1, 64, n);
      check("tcw low div2", n, 3);
      check("tcw busy clear", 32'(busy[0]), 0);
      waitLevel(0, 1'b0, 64, n);
      check("tcw high div1", n, 2);

      // Disable while busy applies the pending divisor
      write(2'd0, 16'd6);
      check("dis busy set", 32'(busy[0]), 1);
      enable[0] = 1'b0;
      tick();
      check("dis busy clear", 32'(busy[0]), 0);
      check("dis clockOut", 32'(clockOut[0]), 0);
      enable[0] = 1'b1;
      waitLevel(0, 1'b1, 64, n);
      check("dis new rise", n, 7);

      // Asynchronous reset pulse between edges
      enable = 4'hF;
      write(2'd3, 16'd5);
      check("pre-reset busy", 32'(busy[3]), 1);
      #5;
      reset = 1'b1;
      #1;
      check("async clockOut", 32'(clockOut), 0);
      check("async busy", 32'(busy), 0);
      check("async busy3", 32'(busy3), 0);
      reset = 1'b0;
      waitLevel(1, 1'b1, 30000, n);
      check("post-reset rise", n, 25000);
      check("post-reset all high", 32'(clockOut), 32'hF);

      // Divisor 0 in pulse mode holds clockOut high
      enable = '0;
      pulseMode = 4'b0010;
      tick();
      write(2'd1, 16'd0);
      enable = 4'b0010;
      tick();
      check("div0 pulse first", 32'(clockOut[1]), 1);
      tick(5);
      check("div0 pulse held", 32'(clockOut[1]), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/programmable_clock_divider.md
Name: programmable_clock_divider

Overview:
- Multi-channel successor to the single fixed-divisor clock divider.
- Each of CHANNELS outputs divides the 50 MHz clockIn by its own runtime-programmable WIDTH-bit divisor.
- Each channel has an independent enable and a square-wave/pulse mode select.
- Divisor and mode changes apply glitch-free, at period boundaries only. The block feeds the display-scan, keypad-debounce and timeout timers of the POS terminal.

Parameters:
CHANNELS, 4, number of independent divider channels (1..16)
WIDTH, 16, divisor/counter width in bits
DEFAULT_DIV, 24999, divisor loaded into every channel at reset (1 kHz square wave from 50 MHz)
CH_BITS, 2, width of wrChannel; must be >= max(1, ceil(log2(CHANNELS)))

Ports:
clockIn  input  1  system clock, 50 MHz, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
wrEn  input  1  single-cycle divisor write strobe
wrChannel  input  CH_BITS  target channel of the write
wrData  input  WIDTH  new divisor value
enable  input  CHANNELS  per-channel run enable
pulseMode  input  CHANNELS  per-channel mode: 0 = 50% square wave, 1 = one-cycle tick
clockOut  output  CHANNELS  registered divided output per channel
busy  output  CHANNELS  1 while a written divisor is pending, not yet active

Behaviour:
- Reset (async, active-high), for every channel:
  - counter = 0, phase = 0, clockOut = 0, busy = 0.
  - activeDiv = shadowDiv = DEFAULT_DIV, activeMode = 0.
- Terminal count (TC) for channel i: enable[i] = 1 and counter == activeDiv.
- Enabled channel, each cycle:
  - At TC: counter <= 0 and phase toggles.
  - Otherwise: counter <= counter + 1.
- Output register, updated every cycle:
  - activeMode = 0: clockOut = next phase, so it toggles on the cycle after TC.
    - Period = 2*(activeDiv+1) clockIn cycles, 50% duty.
  - activeMode = 1: clockOut = 1 on the cycle after TC, else 0.
    - Period = activeDiv+1 cycles, high for exactly 1 cycle.
- Divisor = 0:
  - Square mode gives clockIn/2.
  - Pulse mode gives clockOut constant 1 while enabled.
  - Both are legal.
- Disabled channel (enable[i] = 0):
  - counter held at 0, phase held at 0, clockOut registered 0 on the next edge.
  - activeMode continuously follows pulseMode[i].
- Re-enable:
  - Counting restarts from 0.
  - First TC occurs activeDiv+1 cycles after the first enabled edge.
- Divisor write:
  - wrEn = 1 with wrChannel < CHANNELS: shadowDiv[wrChannel] <= wrData.
  - If the channel is enabled, busy <= 1.
  - If the channel is disabled, activeDiv <= wrData on the same edge and busy stays 0.
  - wrChannel >= CHANNELS: write ignored, no state change.
- Applying a pending divisor:
  - At TC with busy = 1: activeDiv <= shadowDiv, busy <= 0. The new period starts from counter 0.
  - Write on the same edge as TC: the old shadowDiv is applied, and the new value stays pending (busy stays 1) until the next TC.
  - Repeated writes before TC: last write wins.
- Mode change while enabled: pulseMode[i] is sampled into activeMode only at TC. Changes take effect for the following period; no runt pulses.
- enable deasserted while busy: the pending shadowDiv is applied immediately and busy <= 0.
- Reset mid-operation: all outputs drop to 0 asynchronously and all divisors return to DEFAULT_DIV; pending writes are lost.
- Channels are fully independent; simultaneous TCs on several channels are each handled normally.
- Counter width is WIDTH; because counter never exceeds activeDiv, no wrap-around is possible.

Test Plan:
1. Reset, CHANNELS=4, all enabled, pulseMode=0 -> every clockOut toggles every 25000 cycles (period 1 ms); busy stays 0.
2. Channel 1 disabled, write wrData=3 to ch1, then enable -> busy[1] stays 0; clockOut[1] goes high 4 cycles after enable, period 8 cycles, 50% duty.
3. Channel 2 running with div=9, write wrData=1 mid-period -> busy[2]=1 until the next TC; remaining period unchanged (10 cycles), then period 4 cycles; no output pulse shorter than 2 cycles.
4. Channel 0 with pulseMode=1, div=4 -> clockOut[0] high for exactly 1 cycle every 5 cycles. Toggle pulseMode to 0 mid-period -> switches to square wave only after the next TC.
5. wrEn with wrChannel=3, CHANNELS=3 -> no divisor changes, busy all 0. Write coincident with TC on ch0 -> applied one period later.
6. Assert reset for 1 ns mid-count between clock edges -> all clockOut and busy go 0 immediately. After release, channels run at DEFAULT_DIV; div=0 square mode gives clockIn/2.
